fsk_frame_rx: RTL and testbench

FSK_FRAME_RX -- requirements
Module: fsk_frame_rx

---
 rtl/fsk_frame_rx.sv | 128 ++++++++++++
 tb/tb_fsk_frame_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fsk_frame_rx.sv
// Frame receiver for a 2FSK demodulated bit stream: hunts for a sync word,
// then collects an 8-bit payload (MSB first) and one even-parity bit.
//
// Output handshake: data_vld stays high while data_out holds an unconsumed
// byte; the byte is consumed on any clock edge where data_vld and data_rdy
// are both high. data_rdy is ignored while data_vld is low. A frame that
// completes while a byte is still unconsumed overwrites it and pulses overrun,
// unless data_rdy consumes the old byte on that same edge.
module fsk_frame_rx #(
  parameter int         BIT_CYCLES = 2048,
  parameter int         SAMPLE_PT  = 1023,
  parameter logic [7:0] SYNC       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       data_rdy,
  output logic [7:0] data_out,
  output logic       data_vld,
  output logic       parity_err,
  output logic       overrun,
  output logic       lock,
  output logic [7:0] frame_cnt
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAR  = 2'd2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    pay_q, pay_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          parity_err_q, parity_err_d;
  logic          data_vld_q, data_vld_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          bit_stb;
  logic          frame_done;

  assign bit_stb = (cnt_q == CW'(SAMPLE_PT));

  always_comb begin
    cnt_d        = (cnt_q == CW'(BIT_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
    sr_d         = sr_q;
    state_d      = state_q;
    idx_d        = idx_q;
    pay_d        = pay_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    data_vld_d   = data_vld_q;
    overrun_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    frame_done   = 1'b0;

    if (bit_stb) begin
      sr_d = {sr_q[6:0], din};
      case (state_q)
        ST_HUNT: begin
          if ({sr_q[6:0], din} == SYNC) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
        ST_DATA: begin
          pay_d = {pay_q[6:0], din};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_PAR;
        end
        ST_PAR: begin
          frame_done   = 1'b1;
          state_d      = ST_HUNT;
          // Payload bits still sit in sr; wipe them so they cannot complete a sync.
          sr_d         = 8'd0;
          data_out_d   = pay_q;
          parity_err_d = ^{pay_q, din};
          frame_cnt_d  = frame_cnt_q + 8'd1;
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (frame_done) begin
      data_vld_d = 1'b1;
      overrun_d  = data_vld_q & ~data_rdy;
    end else if (data_vld_q && data_rdy) begin
      data_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sr_q         <= 8'd0;
      state_q      <= ST_HUNT;
      idx_q        <= 3'd0;
      pay_q        <= 8'd0;
      data_out_q   <= 8'd0;
      parity_err_q <= 1'b0;
      data_vld_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      pay_q        <= pay_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      data_vld_q   <= data_vld_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign parity_err = parity_err_q;
  assign data_vld   = data_vld_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;
  assign lock       = (state_q == ST_DATA) || (state_q == ST_PAR);

endmodule

// File: tb/tb_fsk_frame_rx.sv
// Directed bench for fsk_frame_rx with a short bit period; every bit window
// is 16 clocks and the DUT strobes on the 8th edge of each window.
module tb_fsk_frame_rx;

  localparam int BIT_CYCLES = 16;
  localparam int SAMPLE_PT  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       data_rdy = 1'b0;
  logic [7:0] data_out;
  logic       data_vld;
  logic       parity_err;
  logic       overrun;
  logic       lock;
  logic [7:0] frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_seen = 0;

  // Samples taken around the strobe of the most recent bit window.
  logic pre_vld, post_vld, post_lock, post_ovr, post2_ovr;
  logic early_lock;

  fsk_frame_rx #(
    .BIT_CYCLES(BIT_CYCLES),
    .SAMPLE_PT (SAMPLE_PT),
    .SYNC      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .data_rdy  (data_rdy),
    .data_out  (data_out),
    .data_vld  (data_vld),
    .parity_err(parity_err),
    .overrun   (overrun),
    .lock      (lock),
    .frame_cnt (frame_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ovr_seen++;

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    din = 1'b0;
    data_rdy = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One bit window; optionally pulse data_rdy on its first edge or on the strobe edge.
  task automatic send_bit(input logic b, input logic rdy_first, input logic rdy_stb);
    din = b;
    data_rdy = rdy_first;
    @(posedge clk); #1;
    data_rdy = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    pre_vld = data_vld;
    data_rdy = rdy_stb;
    @(posedge clk); #1;
    data_rdy = 1'b0;
    post_vld  = data_vld;
    post_lock = lock;
    post_ovr  = overrun;
    @(posedge clk); #1;
    post2_ovr = overrun;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string tag, input logic [7:0] s, input logic [7:0] p,
                            input logic par, input logic rdy_last);
    logic b;
    logic exp_lock;
    early_lock = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 8)       b = s[7-i];
      else if (i < 16) b = p[15-i];
      else             b = par;
      send_bit(b, 1'b0, (i == 16) ? rdy_last : 1'b0);
      exp_lock = (i >= 7) && (i <= 15);
      if (i < 7) early_lock = early_lock | post_lock;
      if (i == 7 || i == 16) check_eq({tag, "_lock_after_stb"}, {7'd0, post_lock}, {7'd0, exp_lock});
    end
  endtask

  task automatic consume_bit(input string tag);
    send_bit(1'b0, 1'b1, 1'b0);
    check_eq({tag, "_vld_cleared"}, {7'd0, pre_vld}, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(3);
    check_eq("rst_vld",   {7'd0, data_vld},   8'd0);
    check_eq("rst_dout",  data_out,           8'd0);
    check_eq("rst_perr",  {7'd0, parity_err}, 8'd0);
    check_eq("rst_ovr",   {7'd0, overrun},    8'd0);
    check_eq("rst_lock",  {7'd0, lock},       8'd0);
    check_eq("rst_fcnt",  frame_cnt,          8'd0);

    // Nominal frame: 3C has four ones, parity bit 0 is correct.
    send_frame("nom", 8'hA5, 8'h3C, 1'b0, 1'b0);
    check_eq("nom_no_early_lock", {7'd0, early_lock}, 8'd0);
    check_eq("nom_vld_pre",  {7'd0, pre_vld},    8'd0);
    check_eq("nom_vld_post", {7'd0, post_vld},   8'd1);
    check_eq("nom_dout",     data_out,           8'h3C);
    check_eq("nom_perr",     {7'd0, parity_err}, 8'd0);
    check_eq("nom_fcnt",     frame_cnt,          8'd1);
    consume_bit("nom");
    check_eq("nom_dout_stable", data_out, 8'h3C);

    // Wrong parity bit.
    send_frame("par", 8'hA5, 8'h3C, 1'b1, 1'b0);
    check_eq("par_dout", data_out,           8'h3C);
    check_eq("par_perr", {7'd0, parity_err}, 8'd1);
    check_eq("par_fcnt", frame_cnt,          8'd2);
    consume_bit("par");

    // Noise 1,1,0,1 ahead of sync.
    send_bit(1'b1, 1'b0, 1'b0); early_lock = post_lock;
    send_bit(1'b1, 1'b0, 1'b0); early_lock = early_lock | post_lock;
    send_bit(1'b0, 1'b0, 1'b0); early_lock = early_lock | post_lock;
    send_bit(1'b1, 1'b0, 1'b0); early_lock = early_lock | post_lock;
    check_eq("noise_no_lock", {7'd0, early_lock}, 8'd0);
    send_frame("noise", 8'hA5, 8'h81, 1'b0, 1'b0);
    check_eq("noise_no_early_lock", {7'd0, early_lock}, 8'd0);
    check_eq("noise_dout", data_out,           8'h81);
    check_eq("noise_perr", {7'd0, parity_err}, 8'd0);
    check_eq("noise_fcnt", frame_cnt,          8'd3);
    consume_bit("noise");

    // Overrun: two frames, nobody consuming.
    ovr_seen = 0;
    send_frame("ovr1", 8'hA5, 8'h11, 1'b0, 1'b0);
    check_eq("ovr1_dout", data_out, 8'h11);
    check_eq("ovr1_ovr",  {7'd0, post_ovr}, 8'd0);
    send_frame("ovr2", 8'hA5, 8'h22, 1'b0, 1'b0);
    check_eq("ovr2_ovr_pulse", {7'd0, post_ovr},  8'd1);
    check_eq("ovr2_ovr_drop",  {7'd0, post2_ovr}, 8'd0);
    check_eq("ovr2_dout",      data_out,          8'h22);
    check_eq("ovr2_vld",       {7'd0, data_vld},  8'd1);
    check_eq("ovr2_fcnt",      frame_cnt,         8'd5);
    check_eq("ovr_pulse_count", ovr_seen[7:0],    8'd1);
    consume_bit("ovr");

    // Accept in the exact completion cycle of the second frame.
    ovr_seen = 0;
    send_frame("acc1", 8'hA5, 8'h11, 1'b0, 1'b0);
    check_eq("acc1_dout", data_out, 8'h11);
    send_frame("acc2", 8'hA5, 8'h22, 1'b0, 1'b1);
    check_eq("acc2_ovr",  {7'd0, post_ovr},  8'd0);
    check_eq("acc2_vld",  {7'd0, post_vld},  8'd1);
    check_eq("acc2_dout", data_out,          8'h22);
    check_eq("acc2_fcnt", frame_cnt,         8'd7);
    check_eq("acc_pulse_count", ovr_seen[7:0], 8'd0);
    consume_bit("acc");

    // Reset after sync plus four payload bits of 5A (0,1,0,1).
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] sw;
      sw = 8'hA5;
      send_bit(sw[i], 1'b0, 1'b0);
    end
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    check_eq("mid_lock_before_rst", {7'd0, lock}, 8'd1);
    do_reset(1);
    check_eq("mid_vld",  {7'd0, data_vld},   8'd0);
    check_eq("mid_dout", data_out,           8'd0);
    check_eq("mid_perr", {7'd0, parity_err}, 8'd0);
    check_eq("mid_ovr",  {7'd0, overrun},    8'd0);
    check_eq("mid_lock", {7'd0, lock},       8'd0);
    check_eq("mid_fcnt", frame_cnt,          8'd0);
    send_frame("post_rst", 8'hA5, 8'h5A, 1'b0, 1'b0);
    check_eq("post_rst_vld",  {7'd0, post_vld},   8'd1);
    check_eq("post_rst_dout", data_out,           8'h5A);
    check_eq("post_rst_perr", {7'd0, parity_err}, 8'd0);
    check_eq("post_rst_fcnt", frame_cnt,          8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
